// File: rtl/pipe_stage_pkg.sv
// Shared types for the elastic pipeline-stage register: FSM state encoding and the
// per-boundary payload structs that parent datapaths pack into the opaque payload.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic [3:0]  alu_op;
        logic [31:0] op_a;
        logic [31:0] op_b;
    } id_ex_payload_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] alu_res;
        logic [31:0] st_data;
    } ex_mem_payload_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_wr;
        logic [31:0] wb_data;
    } mem_wb_payload_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_payload_t);
    localparam int unsigned ID_EX_W  = $bits(id_ex_payload_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_payload_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_payload_t);

    // Bubble encodings: every write enable low so a flushed slot has no side effects.
    localparam if_id_payload_t IF_ID_NOP = '{
        pc:    32'h0,
        instr: INSTR_NOP
    };

    localparam id_ex_payload_t ID_EX_NOP = '{
        pc:     32'h0,
        rd:     5'd0,
        reg_wr: 1'b0,
        mem_rd: 1'b0,
        mem_wr: 1'b0,
        alu_op: 4'd0,
        op_a:   32'h0,
        op_b:   32'h0
    };

    localparam ex_mem_payload_t EX_MEM_NOP = '{
        rd:      5'd0,
        reg_wr:  1'b0,
        mem_rd:  1'b0,
        mem_wr:  1'b0,
        alu_res: 32'h0,
        st_data: 32'h0
    };

    localparam mem_wb_payload_t MEM_WB_NOP = '{
        rd:      5'd0,
        reg_wr:  1'b0,
        wb_data: 32'h0
    };

    function automatic logic state_holds_data(input pipe_state_t st);
        return st != EMPTY;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         CLK,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with flush-to-bubble, optional skid slot
// and saturating stall/flush counters.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int unsigned       SKID      = 1,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              valid_q, valid_d;
    logic              in_xfer, out_xfer;
    logic              stall_inc;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = valid_q & out_ready;

    // Without a skid slot, ONE+input only happens alongside an output transfer, so TWO
    // is unreachable and the same next-state logic serves both configurations.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = FLUSH_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        valid_d = state_holds_data(state_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
            main_q  <= FLUSH_VAL;
            skid_q  <= FLUSH_VAL;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Registered ready breaks the combinational out_ready -> in_ready path.
            logic rdy_q;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (state_d != TWO);
                end
            end

            assign in_ready = rdy_q;
        end else begin : g_noskid
            assign in_ready = out_ready | ~valid_q;
        end
    endgenerate

    assign out_valid = valid_q;
    assign out_data  = main_q;

    assign stall_inc = valid_q & ~out_ready & ~flush;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .CLK(CLK),
        .clr(RST),
        .inc(stall_inc),
        .cnt(stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .CLK(CLK),
        .clr(RST),
        .inc(flush),
        .cnt(flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid stage (A), small-counter skid stage (B), single-slot stage (C).
module tb_pipe_stage_reg;

    logic CLK;
    logic RST;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [31:0] a_in_data, a_out_data;
    logic [15:0] a_stall, a_fcnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [31:0] b_in_data, b_out_data;
    logic [3:0]  b_stall, b_fcnt;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
    logic [31:0] c_in_data, c_out_data;
    logic [15:0] c_stall, c_fcnt;

    int err_cnt = 0;
    int chk_cnt = 0;

    pipe_stage_reg #(
        .DATA_W(32), .FLUSH_VAL(32'hDEAD_0000), .SKID(1), .CNT_W(16)
    ) u_a (
        .CLK(CLK), .RST(RST),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .flush(a_flush), .stall_cnt(a_stall), .flush_cnt(a_fcnt)
    );

    pipe_stage_reg #(
        .DATA_W(32), .FLUSH_VAL(32'h0), .SKID(1), .CNT_W(4)
    ) u_b (
        .CLK(CLK), .RST(RST),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .flush(b_flush), .stall_cnt(b_stall), .flush_cnt(b_fcnt)
    );

    pipe_stage_reg #(
        .DATA_W(32), .FLUSH_VAL(32'h0), .SKID(0), .CNT_W(16)
    ) u_c (
        .CLK(CLK), .RST(RST),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .flush(c_flush), .stall_cnt(c_stall), .flush_cnt(c_fcnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        a_in_valid = 0; a_out_ready = 0; a_flush = 0; a_in_data = '0;
        b_in_valid = 0; b_out_ready = 0; b_flush = 0; b_in_data = '0;
        c_in_valid = 0; c_out_ready = 0; c_flush = 0; c_in_data = '0;

        // 1. reset
        tick();
        tick();
        check("rst_valid", a_out_valid, 0);
        check("rst_data", a_out_data, 32'hDEAD_0000);
        check("rst_ready", a_in_ready, 1);
        check("rst_stall", a_stall, 0);
        check("rst_fcnt", a_fcnt, 0);
        RST = 1'b0;

        // 2. streaming, one-cycle latency
        a_out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            a_in_valid = 1;
            a_in_data  = i;
            #1;
            check("stream_ready", a_in_ready, 1);
            tick();
            check("stream_valid", a_out_valid, 1);
            check("stream_data", a_out_data, i);
        end
        a_in_valid = 0;
        tick();
        check("stream_drain", a_out_valid, 0);

        // 3. backpressure
        a_in_valid = 1; a_in_data = 10; a_out_ready = 1;
        tick();
        check("bp_first", a_out_data, 10);
        a_in_data = 11; a_out_ready = 0;
        tick();
        check("bp_full_ready", a_in_ready, 0);
        a_in_data = 12;
        tick();
        tick();
        check("bp_hold_ready", a_in_ready, 0);
        check("bp_hold_data", a_out_data, 10);
        check("bp_stall3", a_stall, 3);
        a_out_ready = 1;
        #1;
        check("bp_rel_data10", a_out_data, 10);
        tick();
        check("bp_rel_data11", a_out_data, 11);
        check("bp_rel_ready", a_in_ready, 1);
        tick();
        check("bp_rel_data12", a_out_data, 12);
        check("bp_rel_valid", a_out_valid, 1);
        a_in_valid = 0;
        tick();
        check("bp_empty", a_out_valid, 0);
        check("bp_stall_end", a_stall, 3);

        // 4. flush in TWO with payload 99 offered
        a_out_ready = 0; a_in_valid = 1; a_in_data = 20;
        tick();
        a_in_data = 21;
        tick();
        check("fl_two_ready", a_in_ready, 0);
        a_flush = 1; a_in_data = 99;
        tick();
        check("fl_valid", a_out_valid, 0);
        check("fl_data", a_out_data, 32'hDEAD_0000);
        check("fl_fcnt", a_fcnt, 1);
        check("fl_ready", a_in_ready, 1);
        check("fl_stall", a_stall, 4);
        // held flush with inputs offered keeps the stage empty
        a_in_data = 55; a_out_ready = 1;
        tick();
        check("flh_valid1", a_out_valid, 0);
        tick();
        check("flh_valid2", a_out_valid, 0);
        check("flh_data", a_out_data, 32'hDEAD_0000);
        check("flh_fcnt", a_fcnt, 3);
        a_flush = 0; a_in_valid = 0;
        tick();
        check("fl_noleak", a_out_valid, 0);

        // 5. saturation with both slots held, then reset mid-stall
        b_in_valid = 1; b_in_data = 5; b_out_ready = 0;
        tick();
        b_in_data = 6;
        tick();
        b_in_valid = 0;
        repeat (13) tick();
        check("sat_14", b_stall, 14);
        tick();
        check("sat_15", b_stall, 15);
        repeat (5) tick();
        check("sat_hold", b_stall, 15);
        check("sat_data", b_out_data, 5);
        RST = 1;
        tick();
        RST = 0;
        check("sat_rst_cnt", b_stall, 0);
        check("sat_rst_valid", b_out_valid, 0);
        check("sat_rst_ready", b_in_ready, 1);
        check("rst_a_fcnt", a_fcnt, 0);
        b_out_ready = 1;
        tick();
        check("sat_rst_noleak", b_out_valid, 0);

        // 6. single-slot stage
        c_in_valid = 1; c_in_data = 7; c_out_ready = 0;
        #1;
        check("ns_empty_ready", c_in_ready, 1);
        tick();
        check("ns_data7", c_out_data, 7);
        check("ns_valid7", c_out_valid, 1);
        c_in_valid = 0;
        #1;
        check("ns_stall_ready", c_in_ready, 0);
        tick();
        c_in_valid = 1; c_in_data = 8; c_out_ready = 1;
        #1;
        check("ns_pass_ready", c_in_ready, 1);
        tick();
        check("ns_data8", c_out_data, 8);
        check("ns_valid8", c_out_valid, 1);
        c_in_valid = 0; c_in_data = 'x;
        tick();
        check("ns_drain_valid", c_out_valid, 0);
        check("ns_drain_hold", c_out_data, 8);
        tick();
        check("ns_x_block", c_out_data, 8);
        check("ns_stall", c_stall, 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
